// File: rtl/store_size_rmw.sv
// store_size_rmw: store path of the multicycle datapath.
// Accepts a sw/sh/sb request from the control unit and drives the word-wide
// data memory. sw writes the word directly. sh/sb read the word, merge the
// new lane(s), then write the word back.
// All memory-side and handshake outputs are registered, so each output pulse
// appears one cycle after the FSM state that requests it.
// Optional feature macro: ALIGN_CHECK_EN. When it is defined, a misaligned
// sw/sh finishes at once with done and align_err and does not touch memory.
module store_size_rmw #(
   parameter int MEM_RD_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  store_type,
   input  logic [31:0] addr,
   input  logic [31:0] B_out,
   output logic [31:0] mem_addr,
   output logic        mem_wr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic        done,
   output logic        align_err
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      MERGE = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [1:0] ST_SH = 2'b01;
   localparam logic [1:0] ST_SB = 2'b10;

   // Last value of the read wait counter before the read data is valid.
   localparam logic [2:0] RD_LAST = 3'(MEM_RD_LAT - 1);

   state_t      state;
   state_t      state_nx;

   logic [31:0] addr_q;
   logic [31:0] b_q;
   logic [1:0]  type_q;
   logic [31:0] wdata_q;
   logic [2:0]  wait_q;
   logic        mem_wr_q;
   logic        done_q;

   logic        accept;
   logic        is_rmw;
   logic        misaligned;
   logic [31:0] merged;

   // A new request is taken only in IDLE and never in the cycle that shows done.
   assign accept = (state == IDLE) && start && !done_q;

   // Reserved type 2'b11 falls into the sw path.
   assign is_rmw = (store_type == ST_SH) || (store_type == ST_SB);

`ifdef ALIGN_CHECK_EN
   logic err_q;
   logic align_err_q;

   // sb is never misaligned; sh needs halfword alignment; sw and reserved need word alignment.
   assign misaligned = (store_type == ST_SB) ? 1'b0 :
                       (store_type == ST_SH) ? addr[0] :
                                               (addr[1:0] != 2'b00);

   // Remember whether the captured request was rejected, and flag it with done.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_q       <= 1'b0;
         align_err_q <= 1'b0;
      end else begin
         if (accept) begin
            err_q <= misaligned;
         end
         align_err_q <= (state == DONE) && err_q;
      end
   end

   assign align_err = align_err_q;
`else
   assign misaligned = 1'b0;
   assign align_err  = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: clocked state always uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic: sw goes straight to WRITE, sh/sb go through READ and MERGE.
   always_comb begin
      // NOTE: assign the default first so no path leaves state_nx unassigned
      // and no latch is inferred.
      state_nx = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (misaligned) begin
                  state_nx = DONE;
               end else if (is_rmw) begin
                  state_nx = READ;
               end else begin
                  state_nx = WRITE;
               end
            end
         end
         READ: begin
            if (wait_q == RD_LAST) begin
               state_nx = MERGE;
            end
         end
         MERGE:   state_nx = WRITE;
         WRITE:   state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Lane merge: replace the addressed byte or halfword of the read word.
   always_comb begin
      merged = mem_rdata;
      if (type_q == ST_SB) begin
         case (addr_q[1:0])
            2'd0: merged[7:0]   = b_q[7:0];
            2'd1: merged[15:8]  = b_q[7:0];
            2'd2: merged[23:16] = b_q[7:0];
            2'd3: merged[31:24] = b_q[7:0];
            default: merged     = mem_rdata;
         endcase
      end else if (type_q == ST_SH) begin
         if (addr_q[1]) begin
            merged[31:16] = b_q[15:0];
         end else begin
            merged[15:0] = b_q[15:0];
         end
      end else begin
         merged = b_q;
      end
   end

   // Request capture, read wait counter and write-data register.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q  <= 32'd0;
         b_q     <= 32'd0;
         type_q  <= 2'b00;
         wdata_q <= 32'd0;
         wait_q  <= 3'd0;
      end else begin
         if (accept) begin
            addr_q  <= addr;
            b_q     <= B_out;
            type_q  <= store_type;
            wdata_q <= B_out;
         end else if (state == MERGE) begin
            wdata_q <= merged;
         end

         if (state == READ) begin
            wait_q <= wait_q + 3'd1;
         end else begin
            wait_q <= 3'd0;
         end
      end
   end

   // Registered write strobe and done pulse, one cycle after WRITE and DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_wr_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         mem_wr_q <= (state == WRITE);
         done_q   <= (state == DONE);
      end
   end

   assign mem_addr  = {addr_q[31:2], 2'b00};
   assign mem_wdata = wdata_q;
   assign mem_wr    = mem_wr_q;
   assign done      = done_q;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_store_size_rmw.sv
// tb_store_size_rmw: bench for store_size_rmw.
// A small word memory with a MEM_RD_LAT read pipeline serves the DUT. A
// transaction model predicts, cycle by cycle, when busy, mem_wr, done and
// align_err must be high and what word must be written. Directed vectors
// also pin the memory contents and latencies to hand-computed values.
module tb_store_size_rmw;

   localparam int LAT = 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  store_type = 2'b00;
   logic [31:0] addr = 32'd0;
   logic [31:0] B_out = 32'd0;
   logic [31:0] mem_addr;
   logic        mem_wr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy;
   logic        done;
   logic        align_err;

   always #5 clk = ~clk;

   store_size_rmw #(.MEM_RD_LAT(LAT)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .store_type (store_type),
      .addr       (addr),
      .B_out      (B_out),
      .mem_addr   (mem_addr),
      .mem_wr     (mem_wr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .busy       (busy),
      .done       (done),
      .align_err  (align_err)
   );

   // ---------------- memory with read latency ----------------
   logic [31:0] mem [0:255];
   logic [31:0] rd_pipe [0:3];
   logic        init_en = 1'b0;
   logic [7:0]  init_idx = 8'd0;
   logic [31:0] init_val = 32'd0;

   assign mem_rdata = rd_pipe[LAT-1];

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
      end else if (init_en) begin
         mem[init_idx] <= init_val;
      end else if (mem_wr) begin
         mem[mem_addr[9:2]] <= mem_wdata;
      end
      rd_pipe[0] <= mem[mem_addr[9:2]];
      for (int i = 1; i < 4; i++) rd_pipe[i] <= rd_pipe[i-1];
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit model_misaligned(input logic [1:0] t, input logic [31:0] a);
`ifdef ALIGN_CHECK_EN
      if (t == 2'b10) return 1'b0;
      if (t == 2'b01) return a[0];
      return a[1:0] != 2'b00;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] model_merge(input logic [1:0] t, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] old);
      logic [7:0] by [4];
      int k;
      for (int i = 0; i < 4; i++) by[i] = old[8*i +: 8];
      if (t == 2'b10) begin
         by[a[1:0]] = b[7:0];
      end else if (t == 2'b01) begin
         k = a[1] ? 2 : 0;
         by[k]   = b[7:0];
         by[k+1] = b[15:8];
      end else begin
         return b;
      end
      return {by[3], by[2], by[1], by[0]};
   endfunction

   int          cyc = 0;
   int          t0 = 0;
   int          t_done = 0;
   bit          active = 1'b0;
   bit          armed = 1'b0;
   bit          m_err = 1'b0;
   logic [31:0] m_waddr = 32'd0;
   logic [31:0] m_wdata = 32'd0;
   int          wr_count = 0;
   int          done_count = 0;
   int          err_count = 0;

   // Compare process: checks outputs every cycle at the falling edge, then
   // updates the model with what the DUT samples at the next rising edge.
   initial begin
      bit blocked;
      bit e_busy, e_wr, e_done, e_err, rmw;
      forever begin
         @(negedge clk);
         cyc++;
         blocked = 1'b0;
         if (armed) begin
            e_busy = active && (cyc > t0) && (cyc < t_done);
            e_wr   = active && !m_err && (cyc == t_done - 1);
            e_done = active && (cyc == t_done);
            e_err  = e_done && m_err;
            check("busy", 32'(busy), 32'(e_busy));
            check("mem_wr", 32'(mem_wr), 32'(e_wr));
            check("done", 32'(done), 32'(e_done));
            check("align_err", 32'(align_err), 32'(e_err));
            if (active && !m_err && cyc > t0) check("mem_addr", mem_addr, m_waddr);
            if (e_wr) check("mem_wdata", mem_wdata, m_wdata);
            if (mem_wr) wr_count++;
            if (done) done_count++;
            if (align_err) err_count++;
         end
         if (active && cyc == t_done) begin
            active  = 1'b0;
            blocked = 1'b1;
         end
         if (reset) begin
            active = 1'b0;
            armed  = 1'b1;
         end else if (armed && !active && !blocked && start) begin
            rmw     = (store_type == 2'b01) || (store_type == 2'b10);
            t0      = cyc;
            m_err   = model_misaligned(store_type, addr);
            m_waddr = {addr[31:2], 2'b00};
            m_wdata = model_merge(store_type, addr, B_out, mem[addr[9:2]]);
            t_done  = t0 + (m_err ? 2 : (rmw ? 4 + LAT : 3));
            active  = 1'b1;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic mem_init(input logic [7:0] idx, input logic [31:0] val);
      @(posedge clk); #1;
      init_en = 1'b1; init_idx = idx; init_val = val;
      @(posedge clk); #1;
      init_en = 1'b0;
   endtask

   // Issue one request, scramble the live inputs, and return start->done latency.
   task automatic run_op(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
      @(posedge clk); #1;
      store_type = t; addr = a; B_out = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; addr = $urandom; B_out = $urandom;
      lat = 1;
      while (!done && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!done) check("done_timeout", 32'(done), 32'd1);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int lat;
      int w0, d0, e0, n;

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_mem_wr", 32'(mem_wr), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_align_err", 32'(align_err), 32'd0);

      // 1: sw
      w0 = wr_count;
      run_op(2'b00, 32'h10, 32'hDEADBEEF, lat);
      check("sw_latency", 32'(lat), 32'd3);
      check("sw_mem", mem[4], 32'hDEADBEEF);
      check("sw_writes", 32'(wr_count - w0), 32'd1);

      // 2: sb, inner lane and top lane
      mem_init(8'd8, 32'h11223344);
      run_op(2'b10, 32'h22, 32'h000000AB, lat);
      check("sb_latency", 32'(lat), 32'(4 + LAT));
      check("sb_lane2", mem[8], 32'h11AB3344);
      mem_init(8'd8, 32'h11223344);
      run_op(2'b10, 32'h23, 32'hFFFFFFAB, lat);
      check("sb_lane3", mem[8], 32'hAB223344);

      // 3: sh, upper and lower halfword
      mem_init(8'd12, 32'hAABBCCDD);
      run_op(2'b01, 32'h32, 32'h00001234, lat);
      check("sh_upper", mem[12], 32'h1234CCDD);
      mem_init(8'd12, 32'hAABBCCDD);
      run_op(2'b01, 32'h30, 32'hFFFF1234, lat);
      check("sh_lower", mem[12], 32'hAABB1234);

      // 4: start re-pulsed mid sh with new data, and held in the done cycle
      mem_init(8'd12, 32'hAABBCCDD);
      w0 = wr_count; d0 = done_count;
      @(posedge clk); #1;
      store_type = 2'b01; addr = 32'h30; B_out = 32'h00005678; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; addr = 32'h32; B_out = 32'h0000FFFF;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (!done && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      if (!done) check("t4_done_timeout", 32'(done), 32'd1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("restart_data", mem[12], 32'hAABB5678);
      check("restart_writes", 32'(wr_count - w0), 32'd1);
      check("restart_dones", 32'(done_count - d0), 32'd1);
      check("restart_idle", 32'(busy), 32'd0);

      // 5: reset during READ of sb, then a normal sw
      mem_init(8'd8, 32'h11223344);
      w0 = wr_count; d0 = done_count;
      @(posedge clk); #1;
      store_type = 2'b10; addr = 32'h22; B_out = 32'h000000AB; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      repeat (10) @(posedge clk);
      #1;
      check("abort_writes", 32'(wr_count - w0), 32'd0);
      check("abort_dones", 32'(done_count - d0), 32'd0);
      run_op(2'b00, 32'h50, 32'hCAFEF00D, lat);
      check("after_abort_mem", mem[20], 32'hCAFEF00D);
      check("after_abort_latency", 32'(lat), 32'd3);

      // Address wrap at the top word, sb never misaligned
      run_op(2'b10, 32'hFFFFFFFF, 32'h0000005A, lat);
      check("wrap_sb", mem[255], 32'h5A000000);

      // sh with addr[0]=1 and sw at 0x41
      mem_init(8'd12, 32'hAABBCCDD);
      w0 = wr_count; e0 = err_count;
      run_op(2'b01, 32'h31, 32'h00001234, lat);
`ifdef ALIGN_CHECK_EN
      check("sh_odd_mem", mem[12], 32'hAABBCCDD);
      check("sh_odd_latency", 32'(lat), 32'd2);
`else
      check("sh_odd_mem", mem[12], 32'hAABB1234);
`endif
      run_op(2'b00, 32'h41, 32'h0BADCAFE, lat);
`ifdef ALIGN_CHECK_EN
      check("sw_mis_latency", 32'(lat), 32'd2);
      check("sw_mis_mem", mem[16], 32'd0);
      check("mis_writes", 32'(wr_count - w0), 32'd0);
      check("mis_errs", 32'(err_count - e0), 32'd2);
`else
      check("sw_mis_latency", 32'(lat), 32'd3);
      check("sw_mis_mem", mem[16], 32'h0BADCAFE);
      check("mis_writes", 32'(wr_count - w0), 32'd2);
      check("mis_errs", 32'(err_count - e0), 32'd0);
`endif

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
